// File: rtl/alu_arbiter.sv
// Shares one combinational 32-bit ALU among NREQ requesters. Ops run strictly one at a time.
// Default arbitration is round-robin; defining ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module alu_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_r1,
  input  logic [32*NREQ-1:0]   req_r2,
  input  logic [4*NREQ-1:0]    req_control,
  output logic [31:0]          alu_r1,
  output logic [31:0]          alu_r2,
  output logic [3:0]           alu_control,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic           found;
  logic [IDW-1:0] gnt;
  logic           grant;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        gnt   = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr;

  // Search starts one past the last grantee and wraps, so the last grantee has lowest priority.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= IDW'(NREQ - 1);
    else if (grant) ptr <= gnt;
  end
`endif

  assign grant = rst_n && (state_q == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_r1      <= '0;
      alu_r2      <= '0;
      alu_control <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          alu_r1      <= req_r1[32*int'(gnt) +: 32];
          alu_r2      <= req_r2[32*int'(gnt) +: 32];
          alu_control <= req_control[4*int'(gnt) +: 4];
          rsp_id      <= gnt;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized ops against a behavioural arbiter/ALU model.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [32*NREQ-1:0]  req_r1, req_r2;
  logic [4*NREQ-1:0]   req_control;
  logic [31:0]         alu_r1, alu_r2, alu_result, rsp_result;
  logic [3:0]          alu_control;
  logic                alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [IDW-1:0]      rsp_id;

  int checks = 0;
  int passes = 0;
  int last;  // model: index of the most recent grantee
  logic [31:0] op_r1 [NREQ];
  logic [31:0] op_r2 [NREQ];
  logic [3:0]  op_ctl[NREQ];

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_r1(req_r1), .req_r2(req_r2), .req_control(req_control),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  // ALU stub: returns {zero, result}. 1000 = beq-style, 1001 = bne-style, 1010..1111 = nothing.
  function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic z;
    r = '0;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = {31'd0, $signed(a) < $signed(b)};
      4'd8, 4'd9: r = a - b;
      default: r = '0;
    endcase
    if (c == 4'd8)      z = (a == b);
    else if (c == 4'd9) z = (a != b);
    else if (c > 4'd9)  z = 1'b0;
    else                z = (r == 0);
    return {z, r};
  endfunction

  always_comb {alu_zero, alu_result} = alu_ref(alu_control, alu_r1, alu_r2);

  function automatic int exp_grant(input logic [NREQ-1:0] m);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (m[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (m[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    op_r1[i] = a; op_r2[i] = b; op_ctl[i] = c;
    req_r1[32*i +: 32] = a;
    req_r2[32*i +: 32] = b;
    req_control[4*i +: 4] = c;
    req_valid[i] = 1'b1;
  endtask

  // Called just after a posedge with the DUT idle and requests driven; runs one op to acceptance.
  task automatic do_op(input int hold, input bit keep, input bit churn, output int g);
    logic [32:0] e;
    int j;
    #1;
    g = exp_grant(req_valid);
    if (g < 0) begin
      checks++;
      $display("FAIL do_op_no_request got mask=%b want nonzero", req_valid);
      return;
    end
    e = alu_ref(op_ctl[g], op_r1[g], op_r2[g]);
    checks++;
    if (req_ready !== NREQ'(1 << g)) $display("FAIL grant got %b want %b", req_ready, NREQ'(1 << g));
    else passes++;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last = g;
`endif
    @(posedge clk); #1;
    if (!keep) req_valid[g] = 1'b0;
    checks++;
    if ({alu_r1, alu_r2, alu_control, rsp_valid, req_ready} !== {op_r1[g], op_r2[g], op_ctl[g], 1'b0, NREQ'(0)})
      $display("FAIL exec_latch got r1=%h r2=%h ctl=%h v=%b rdy=%b want r1=%h r2=%h ctl=%h v=0 rdy=0",
               alu_r1, alu_r2, alu_control, rsp_valid, req_ready, op_r1[g], op_r2[g], op_ctl[g]);
    else passes++;
    @(posedge clk); #1;
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, req_ready} !== {1'b1, IDW'(g), e[31:0], e[32], NREQ'(0)})
        $display("FAIL response[%0d] got v=%b id=%0d res=%h z=%b rdy=%b want v=1 id=%0d res=%h z=%b rdy=0",
                 h, rsp_valid, rsp_id, rsp_result, rsp_zero, req_ready, g, e[31:0], e[32]);
      else passes++;
      if (churn) begin
        j = $urandom_range(NREQ - 1);
        if (!req_valid[j]) set_req(j, $urandom, $urandom, 4'($urandom));
      end
      if (h < hold) begin @(posedge clk); #1; end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL accept got rsp_valid=%b want 0", rsp_valid);
    else passes++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    last = NREQ - 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_r1 = '0; req_r2 = '0; req_control = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid = 4'b0011;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, alu_r1, alu_r2, alu_control} !== '0)
      $display("FAIL reset_state got rdy=%b v=%b id=%0d res=%h z=%b ctl=%h", req_ready, rsp_valid, rsp_id,
               rsp_result, rsp_zero, alu_control);
    else passes++;
    req_valid = '0;
    do_reset();
    rsp_ready = 1'b1;  // ignored while no response is pending
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({req_ready, rsp_valid} !== '0) $display("FAIL idle_quiet got rdy=%b v=%b want 0", req_ready, rsp_valid);
      else passes++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_single();
    int g;
    set_req(0, 32'd5, 32'd7, 4'b0000);
    do_op(0, 1'b0, 1'b0, g);
    checks++;
    if (rsp_result !== 32'd12) $display("FAIL single_sum got %0d want 12", rsp_result);
    else passes++;
  endtask

  task automatic test_branch();
    int g;
    set_req(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1000);
    do_op(0, 1'b0, 1'b0, g);
    set_req(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1001);
    do_op(0, 1'b0, 1'b0, g);
    set_req(2, 32'h1234_5678, 32'h1, 4'b1100);
    do_op(0, 1'b0, 1'b0, g);
  endtask

  task automatic test_round_robin();
    int g;
    time t_prev, t_now;
    int seq[4];
    set_req(0, 32'd1, 32'd2, 4'd0);
    set_req(1, 32'd9, 32'd3, 4'd1);
    t_prev = 0;
    for (int n = 0; n < 4; n++) begin
      t_now = $time;
      do_op(0, 1'b1, 1'b0, g);
      seq[n] = g;
      if (n > 0) begin
        checks++;
        if (t_now - t_prev != 30) $display("FAIL rr_spacing got %0t want 30", t_now - t_prev);
        else passes++;
      end
      t_prev = t_now;
    end
    checks++;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if ({seq[0], seq[1], seq[2], seq[3]} !== {32'd0, 32'd0, 32'd0, 32'd0})
`else
    if ({seq[0], seq[1], seq[2], seq[3]} !== {32'd0, 32'd1, 32'd0, 32'd1})
`endif
      $display("FAIL rr_sequence got %0d,%0d,%0d,%0d", seq[0], seq[1], seq[2], seq[3]);
    else passes++;
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g;
    set_req(3, 32'hFFFF_FFF0, 32'h10, 4'd0);
    do_op(5, 1'b0, 1'b0, g);
    set_req(0, 32'h8000_0000, 32'd1, 4'd7);
    do_op(0, 1'b0, 1'b0, g);
  endtask

  task automatic test_reset_mid_op();
    int g;
    set_req(0, 32'd3, 32'd4, 4'd2);
    #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL midop_grant got %b want 0001", req_ready);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, alu_control, req_ready, rsp_id} !== '0)
      $display("FAIL midop_reset got v=%b ctl=%h rdy=%b id=%0d want 0", rsp_valid, alu_control, req_ready, rsp_id);
    else passes++;
    req_valid = '0;
    do_reset();
    set_req(0, 32'd11, 32'd22, 4'd3);
    set_req(1, 32'd33, 32'd44, 4'd4);
    do_op(0, 1'b0, 1'b0, g);
    req_valid = '0;
    set_req(1, 32'd33, 32'd44, 4'd4);
    do_op(0, 1'b0, 1'b0, g);
  endtask

  task automatic test_random();
    int g;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < NREQ; j++) begin
        a = $urandom;
        if (!req_valid[j] && ($urandom_range(1) == 1))
          set_req(j, a, ($urandom_range(3) == 0) ? a : $urandom, 4'($urandom));
      end
      if (req_valid == '0) set_req($urandom_range(NREQ - 1), $urandom, $urandom, 4'($urandom));
      do_op($urandom_range(3), 1'b0, 1'b1, g);
    end
    req_valid = '0;
  endtask

  initial begin
    last = NREQ - 1;
    test_reset();
    test_single();
    test_branch();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got run still active want finished");
    $fatal(1, "timeout");
  end
endmodule
